layernorm_requant_stage: RTL and testbench

- Streaming requantizer placed directly downstream of the layernorm normalise multiplier (19-bit signed centred value × 16-bit signed inverse-std → 35-bit signed product).
- Per element: round and arithmetic-shift the product, add a per-element beta bias, saturate to the 16-bit output format.
- Valid/ready handshaked, 2-stage pipeline.
- Tags the last element of each row and keeps a saturation statistics counter.

---
 rtl/layernorm_pkg.sv | 37 +++
 rtl/layernorm_requant_stage_round_shift_sat.sv | 33 +++
 rtl/layernorm_requant_stage.sv | 133 +++++++++++++
 tb/tb_layernorm_requant_stage.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/layernorm_pkg.sv
// rtl/layernorm_pkg.sv - shared widths, types and clamp helper for the layernorm requant stage
package layernorm_pkg;

    localparam int PROD_W_DEF = 35;
    localparam int SHIFT_DEF  = 18;
    localparam int OUT_W_DEF  = 16;
    localparam int N_ELEM_DEF = 8;
    localparam int CNT_W_DEF  = 16;

    typedef logic signed [PROD_W_DEF-1:0] prod_t;
    typedef logic signed [OUT_W_DEF-1:0]  act_t;

    typedef struct packed {
        logic               ovf;
        logic signed [63:0] val;
    } clip_t;

    // Clamp a sign-extended value into a signed range of the given width.
    function automatic clip_t sat_clip(input logic signed [63:0] value, input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        clip_t              res;
        hi      = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo      = -(64'sd1 <<< (width - 1));
        res.ovf = 1'b1;
        res.val = value;
        if (value > hi) begin
            res.val = hi;
        end else if (value < lo) begin
            res.val = lo;
        end else begin
            res.ovf = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/layernorm_requant_stage_round_shift_sat.sv
// rtl/layernorm_requant_stage_round_shift_sat.sv - combinational round/shift, bias add and clamp
module round_shift_sat
    import layernorm_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int SHIFT  = SHIFT_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int R_W    = PROD_W - SHIFT + 1
) (
    input  logic signed [PROD_W-1:0] in_prod,
    output logic signed [R_W-1:0]    rs_val,
    input  logic signed [R_W-1:0]    sum_r,
    input  logic signed [OUT_W-1:0]  sum_bias,
    output logic signed [OUT_W-1:0]  clip_data,
    output logic                     clip_sat
);
    localparam int SUM_W = ((R_W > OUT_W) ? R_W : OUT_W) + 1;
    localparam logic signed [PROD_W:0] HALF = (PROD_W + 1)'(1) << (SHIFT - 1);

    logic signed [PROD_W:0]  biased;
    logic signed [SUM_W-1:0] sum;
    clip_t                   clip;

    // One guard bit keeps the half-LSB add from wrapping; the slice is the arithmetic shift.
    assign biased = $signed({in_prod[PROD_W-1], in_prod}) + HALF;
    assign rs_val = biased[PROD_W:SHIFT];

    assign sum       = SUM_W'(sum_r) + SUM_W'(sum_bias);
    assign clip      = sat_clip(64'(sum), OUT_W);
    assign clip_data = OUT_W'(clip.val);
    assign clip_sat  = clip.ovf;

endmodule

// File: rtl/layernorm_requant_stage.sv
// rtl/layernorm_requant_stage.sv - 2-stage handshaked requantizer with row tagging and saturation stats
module layernorm_requant_stage
    import layernorm_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int SHIFT  = SHIFT_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter int N_ELEM = N_ELEM_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst_n,
    input  logic signed [PROD_W-1:0] in_data,
    input  logic signed [OUT_W-1:0]  in_bias,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     clr_stats,
    output logic [CNT_W-1:0]         sat_cnt
);
    localparam int R_W   = PROD_W - SHIFT + 1;
    localparam int IDX_W = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEM - 1);

    logic                    en;
    logic                    accept;
    logic                    is_last;
    logic signed [R_W-1:0]   rs_val;
    logic signed [OUT_W-1:0] clip_data;
    logic                    clip_sat;

    logic                    s1_valid_q, s1_valid_d;
    logic signed [R_W-1:0]   s1_r_q, s1_r_d;
    logic signed [OUT_W-1:0] s1_bias_q, s1_bias_d;
    logic                    s1_last_q, s1_last_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [OUT_W-1:0] out_data_q, out_data_d;
    logic                    out_last_q, out_last_d;
    logic                    sat_q, sat_d;
    logic [IDX_W-1:0]        elem_idx_q, elem_idx_d;
    logic [CNT_W-1:0]        sat_cnt_q, sat_cnt_d;

    round_shift_sat #(
        .PROD_W (PROD_W),
        .SHIFT  (SHIFT),
        .OUT_W  (OUT_W),
        .R_W    (R_W)
    ) u_round_shift_sat (
        .in_prod   (in_data),
        .rs_val    (rs_val),
        .sum_r     (s1_r_q),
        .sum_bias  (s1_bias_q),
        .clip_data (clip_data),
        .clip_sat  (clip_sat)
    );

    // The whole pipe moves as one; only a held output beat stalls it.
    assign en      = !out_valid_q || out_ready;
    assign accept  = in_valid && en;
    assign is_last = (elem_idx_q == LAST_IDX);

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_r_d      = s1_r_q;
        s1_bias_d   = s1_bias_q;
        s1_last_d   = s1_last_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        sat_d       = sat_q;
        elem_idx_d  = elem_idx_q;
        sat_cnt_d   = sat_cnt_q;

        if (en) begin
            s1_valid_d  = accept;
            s1_r_d      = rs_val;
            s1_bias_d   = in_bias;
            s1_last_d   = is_last;
            out_valid_d = s1_valid_q;
            out_last_d  = s1_last_q;
            if (s1_valid_q) begin
                out_data_d = clip_data;
                sat_d      = clip_sat;
            end
        end

        if (accept) begin
            elem_idx_d = is_last ? '0 : elem_idx_q + 1'b1;
        end

        if (clr_stats) begin
            sat_cnt_d = '0;
        end else if (out_valid_q && out_ready && sat_q && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_r_q      <= '0;
            s1_bias_q   <= '0;
            s1_last_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            sat_q       <= 1'b0;
            elem_idx_q  <= '0;
            sat_cnt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_r_q      <= s1_r_d;
            s1_bias_q   <= s1_bias_d;
            s1_last_q   <= s1_last_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            sat_q       <= sat_d;
            elem_idx_q  <= elem_idx_d;
            sat_cnt_q   <= sat_cnt_d;
        end
    end

    assign in_ready  = en;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_valid = out_valid_q;
    assign sat_cnt   = sat_cnt_q;

endmodule

// File: tb/tb_layernorm_requant_stage.sv
// tb/tb_layernorm_requant_stage.sv - scoreboard bench for layernorm_requant_stage
module tb_layernorm_requant_stage;
    import layernorm_pkg::*;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic [34:0] in_data = '0;
    logic [15:0] in_bias = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        clr_stats = 1'b0;
    logic [15:0] sat_cnt;

    logic        in_ready2;
    logic [15:0] out_data2;
    logic        out_last2;
    logic        out_valid2;
    logic [1:0]  sat_cnt2;

    always #5 ap_clk = ~ap_clk;

    layernorm_requant_stage dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_data(in_data), .in_bias(in_bias),
        .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .clr_stats(clr_stats), .sat_cnt(sat_cnt)
    );

    layernorm_requant_stage #(.N_ELEM(1), .CNT_W(2)) dut2 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .in_data(in_data), .in_bias(in_bias),
        .in_valid(in_valid), .in_ready(in_ready2), .out_data(out_data2), .out_last(out_last2),
        .out_valid(out_valid2), .out_ready(out_ready), .clr_stats(clr_stats), .sat_cnt(sat_cnt2)
    );

    typedef struct {
        logic [15:0] data;
        logic        last;
        logic        sat;
        int          cyc;
    } exp_t;

    exp_t   sbq[$];
    exp_t   mon_e;
    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc = 0;
    int     idx = 0;
    int     pops = 0;
    int     pops_before;
    longint exp_cnt = 0;
    longint exp_cnt2 = 0;
    bit     chk_lat = 0;
    bit     rnd_mode = 0;
    bit     saw_stall = 0;
    bit     prev_stall = 0;
    logic [15:0] prev_data;
    logic        prev_last;

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [34:0] d, input logic [15:0] b);
        longint x, r, s;
        exp_t   e;
        x = longint'($signed(d));
        r = (x + 64'sd131072) >>> 18;
        s = r + longint'($signed(b));
        e.sat = (s > 32767) || (s < -32768);
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        e.data = 16'(s);
        e.last = 1'b0;
        e.cyc  = 0;
        return e;
    endfunction

    task automatic send(input logic [34:0] d, input logic [15:0] b,
                        input logic [15:0] ed, input bit es);
        exp_t e;
        bit   done = 0;
        in_data  = d;
        in_bias  = b;
        in_valid = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge ap_clk);
            if (in_ready) begin
                e.data = ed;
                e.sat  = es;
                e.last = (idx == 7);
                e.cyc  = cyc;
                sbq.push_back(e);
                idx  = (idx == 7) ? 0 : idx + 1;
                done = 1;
            end
            @(posedge ap_clk);
            #1;
        end
        if (!done) chk("send_timeout", 64'd0, 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && sbq.size() > 0; t++) @(negedge ap_clk);
        chk("drain_empty", 64'(sbq.size()), 64'd0);
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        sbq.delete();
        idx = 0;
        repeat (2) @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
    endtask

    // Monitor: sat counter model, stall stability and scoreboard pops.
    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            prev_stall = 0;
            exp_cnt    = 0;
            exp_cnt2   = 0;
        end else begin
            chk("sat_cnt", 64'(sat_cnt), 64'(exp_cnt));
            chk("sat_cnt2", 64'(sat_cnt2), 64'(exp_cnt2));
            if (prev_stall) begin
                chk("stall_valid", 64'(out_valid), 64'd1);
                chk("stall_data", 64'(out_data), 64'(prev_data));
                chk("stall_last", 64'(out_last), 64'(prev_last));
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (out_valid && !in_ready) saw_stall = 1;
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_beat", 64'd1, 64'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    pops++;
                    chk("data", 64'(out_data), 64'(mon_e.data));
                    chk("last", 64'(out_last), 64'(mon_e.last));
                    chk("last_n1", 64'(out_last2), 64'd1);
                    if (chk_lat) chk("latency", 64'(cyc - mon_e.cyc), 64'd2);
                    if (mon_e.sat) begin
                        if (exp_cnt < 65535) exp_cnt++;
                        if (exp_cnt2 < 3) exp_cnt2++;
                    end
                end
            end
            if (clr_stats) begin
                exp_cnt  = 0;
                exp_cnt2 = 0;
            end
        end
    end

    always @(posedge ap_clk) begin
        #1;
        if (rnd_mode) out_ready = ($urandom_range(0, 1) == 1);
    end

    initial begin
        logic [63:0]        rw;
        logic signed [33:0] sm;
        logic [34:0]        d;
        logic [15:0]        b;
        exp_t               e;

        do_reset();
        chk("rst_out_valid_rel", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_last", 64'(out_last), 64'd0);
        chk("rst_sat_cnt", 64'(sat_cnt), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        chk_lat = 1;
        send(35'd262144, 16'd0, 16'd1, 0);
        send(35'd393216, 16'd0, 16'd2, 0);
        send(-35'sd393216, 16'd0, 16'hFFFF, 0);
        send(35'd131071, 16'd0, 16'd0, 0);
        drain();
        chk("round_sat_cnt", 64'(sat_cnt), 64'd0);
        send(35'd0, 16'd100, 16'd100, 0);
        send(35'h3_FFFF_FFFF, 16'd0, 16'd32767, 1);
        send(35'h4_0000_0000, 16'hFFFF, 16'h8000, 1);
        drain();
        chk("bias_sat_cnt", 64'(sat_cnt), 64'd2);
        chk_lat = 0;

        do_reset();
        saw_stall   = 0;
        pops_before = pops;
        fork
            begin
                for (int i = 1; i <= 8; i++) send(35'(i) << 18, 16'd0, 16'(i), 0);
            end
            begin
                repeat (3) @(posedge ap_clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge ap_clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("bp_in_ready_dropped", 64'(saw_stall), 64'd1);
        chk("bp_beat_count", 64'(pops - pops_before), 64'd8);

        do_reset();
        for (int i = 1; i <= 20; i++) send(35'(i) << 18, 16'(i), 16'(2 * i), 0);
        drain();
        for (int i = 1; i <= 11; i++) send(35'(i) << 18, 16'd0, 16'(i), 0);
        do_reset();
        for (int i = 1; i <= 9; i++) send(35'(i) << 18, 16'd3, 16'(i + 3), 0);
        drain();

        do_reset();
        for (int i = 0; i < 3; i++) send(35'h3_FFFF_FFFF, 16'd0, 16'd32767, 1);
        drain();
        chk("stats_three", 64'(sat_cnt), 64'd3);
        send(35'h3_FFFF_FFFF, 16'd0, 16'd32767, 1);
        @(posedge ap_clk);
        #1 clr_stats = 1'b1;
        @(posedge ap_clk);
        #1 clr_stats = 1'b0;
        drain();
        chk("stats_clear_wins", 64'(sat_cnt), 64'd0);
        send(35'h4_0000_0000, 16'd0, 16'h8000, 1);
        drain();
        chk("stats_after_clear", 64'(sat_cnt), 64'd1);
        for (int i = 0; i < 5; i++) send(35'h3_FFFF_FFFF, 16'd5, 16'd32767, 1);
        drain();
        chk("stats_main_six", 64'(sat_cnt), 64'd6);
        chk("stats_cnt2_sticks", 64'(sat_cnt2), 64'd3);

        do_reset();
        rnd_mode = 1;
        for (int i = 0; i < 10000; i++) begin
            repeat ($urandom_range(0, 1)) begin
                @(posedge ap_clk);
                #1;
            end
            rw = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) begin
                d = rw[34:0];
            end else begin
                sm = rw[33:0];
                d  = 35'(sm);
            end
            b = 16'($urandom);
            e = model(d, b);
            send(d, b, e.data, e.sat);
        end
        rnd_mode = 0;
        repeat (2) @(posedge ap_clk);
        #1 out_ready = 1'b1;
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
